// File: rtl/mult_result_collector.sv
// Valid/ready wrapper around a 2-stage pipelined multiplier; completed products land in an output FIFO.
// Optional request tags are carried alongside the products when MULT_COLLECT_ID_EN is defined.
module mult_result_collector #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int IDW   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_mcand,
  input  logic [WIDTH-1:0]     in_mplier,
  input  logic [IDW-1:0]       in_id,
  output logic                 mul_en,
  output logic [WIDTH-1:0]     mul_mcand,
  output logic [WIDTH-1:0]     mul_mplier,
  input  logic [2*WIDTH-1:0]   mul_product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [IDW-1:0]       out_id,
  output logic [15:0]          done_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [2:1]         vld_pipe_q, vld_pipe_d;
  logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [15:0]        done_q, done_d;
  logic [2*WIDTH-1:0] prod_mem_q [DEPTH];
  logic               full, push, pop;

  // Stall only when a real product would otherwise be dropped; costs one bubble even if a pop is pending.
  assign full       = (cnt_q == FULL_CNT);
  assign mul_en     = !(vld_pipe_q[2] && full);
  assign in_ready   = mul_en;
  assign mul_mcand  = in_mcand;
  assign mul_mplier = in_mplier;
  assign push       = mul_en && vld_pipe_q[2];
  assign pop        = (cnt_q != '0) && out_ready;

  assign out_valid   = (cnt_q != '0);
  assign out_product = prod_mem_q[rptr_q];
  assign done_count  = done_q;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (mul_en) vld_pipe_d = {vld_pipe_q[1], in_valid};
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    done_d = done_q + 16'(push);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      done_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) prod_mem_q[wptr_q] <= mul_product;
  end

`ifdef MULT_COLLECT_ID_EN
  logic [2:1][IDW-1:0] id_pipe_q;
  logic [IDW-1:0]      id_mem_q [DEPTH];

  // Tags shadow the multiplier's internal registers, so they advance on the same enable.
  always_ff @(posedge clk) begin
    if (!reset)      id_pipe_q <= '0;
    else if (mul_en) id_pipe_q <= {id_pipe_q[1], in_id};
  end

  always_ff @(posedge clk) begin
    if (push) id_mem_q[wptr_q] <= id_pipe_q[2];
  end

  assign out_id = id_mem_q[rptr_q];
`else
  logic unused_id;
  assign unused_id = ^in_id;
  assign out_id    = '0;
`endif

endmodule

// File: tb/tb_mult_result_collector.sv
// Scoreboard bench for mult_result_collector with an inline behavioural 2-stage multiplier.
module tb_mult_result_collector;
  localparam int W = 32;
  localparam int D = 4;
  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_mcand = '0, in_mplier = '0;
  logic [IDW-1:0] in_id = '0;
  logic           mul_en;
  logic [W-1:0]   mul_mcand, mul_mplier;
  logic [2*W-1:0] mul_product;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] out_product;
  logic [IDW-1:0] out_id;
  logic [15:0]    done_count;

  mult_result_collector #(.WIDTH(W), .DEPTH(D), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_mcand(in_mcand), .in_mplier(in_mplier), .in_id(in_id),
    .mul_en(mul_en), .mul_mcand(mul_mcand), .mul_mplier(mul_mplier),
    .mul_product(mul_product), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_id(out_id), .done_count(done_count)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: two enabled register stages, its own state never reset.
  logic [2*W-1:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    if (mul_en) begin
      p1 <= {{W{1'b0}}, mul_mcand} * {{W{1'b0}}, mul_mplier};
      p2 <= p1;
    end
  end
  assign mul_product = p2;

  typedef struct packed {
    logic [2*W-1:0] p;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] exp_done = '0;
  bit          rand_rdy = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  // Monitor: pops the scoreboard on every handshake, in a stable window after the falling edge.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: got %h want none", out_product);
      end else begin
        e = q.pop_front();
        chk("product", out_product, e.p);
`ifdef MULT_COLLECT_ID_EN
        chk("out_id", out_id, e.id);
`else
        chk("out_id_zero", out_id, 0);
`endif
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [IDW-1:0] id);
    int tmo;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_mcand = a; in_mplier = b; in_id = id;
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
    #1;
    tmo = 0;
    while (!in_ready && tmo < 50) begin
      @(negedge clk);
      if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
      #1;
      tmo++;
    end
    if (in_ready) begin
      e.p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e.id = id;
      q.push_back(e);
      exp_done++;
    end else begin
      n_chk++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
      in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic drain();
    int tmo;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    tmo = 0;
    while (q.size() != 0 && tmo < 200) begin
      @(negedge clk);
      tmo++;
    end
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
    repeat (4) @(negedge clk);
    #1;
    chk("drained_out_valid", out_valid, 0);
    chk("done_count", done_count, exp_done);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    q.delete();
    exp_done = '0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] base;
    logic [W-1:0] ones;
    ones = '1;

    // Reset held with in_valid asserted.
    reset = 1'b0; in_valid = 1'b1; in_mcand = 32'd9; in_mplier = 32'd9;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_done_count", done_count, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;

    // Single pair latency.
    out_ready = 1'b1;
    send(32'd3, 32'd5, 4'h1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("lat_edge1_valid", out_valid, 0);
    @(negedge clk);
    #1 chk("lat_edge2_valid", out_valid, 0);
    @(negedge clk);
    #1 chk("lat_edge3_valid", out_valid, 1);
    chk("lat_product", out_product, 64'd15);
    chk("lat_done", done_count, 16'd1);
    drain();

    // Largest operands.
    send(ones, ones, 4'h2);
    drain();
    chk("max_done", done_count, 16'd2);

    // Fill FIFO with consumer stalled.
    base = done_count;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(W'(i), 32'd2, IDW'(i));
    @(negedge clk);
    in_valid = 1'b1; in_mcand = 32'd6; in_mplier = 32'd2;
    repeat (3) @(negedge clk);
    #1;
    chk("stall_in_ready", in_ready, 0);
    chk("stall_mul_en", mul_en, 0);
    chk("stall_done", done_count, base + 16'd4);
    chk("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    send(32'd6, 32'd2, 4'h6);
    send(32'd7, 32'd2, 4'h7);
    drain();

    // Reset mid-flight.
    out_ready = 1'b1;
    send(32'd11, 32'd1, 4'h3);
    send(32'd12, 32'd1, 4'h4);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("post_rst_valid", out_valid, 0);
    end
    send(32'd7, 32'd6, 4'h5);
    drain();
    chk("post_rst_done", done_count, 16'd1);

    // Tags with a bubble between.
    send(32'd10, 32'd10, 4'hA);
    idle();
    send(32'd20, 32'd3, 4'hB);
    drain();

    // Randomized traffic with random backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] a, b;
      case ($urandom_range(0, 7))
        0:       a = '0;
        1:       a = '1;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      if ($urandom_range(0, 3) != 0) send(a, b, IDW'($urandom));
      else idle();
    end
    rand_rdy = 0;
    drain();

    // done_count wrap.
    do_reset(2);
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) send(W'($urandom), W'($urandom), IDW'($urandom));
    drain();
    chk("wrap_ffff", done_count, 16'hFFFF);
    send(32'd5, 32'd5, 4'hC);
    drain();
    chk("wrap_zero", done_count, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
